// File: rtl/usk_pkg.sv
// Shared encodings for the universal shift register: direct-op mode codes
// and the multi-shift sequencer state encoding.
package usk_pkg;

   // Direct-op select codes (also used as the latched multi-shift direction)
   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHL  = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   // Multi-shift sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/usr_next_val.sv
// Combinational next-value mux for the shift register. The same mux serves
// direct ops and sequencer steps; the top decides which op/rot reach it.
module usr_next_val
   import usk_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_q,
   input  logic [1:0]       i_op,
   input  logic             i_rot,
   input  logic             i_ser_l,
   input  logic             i_ser_r,
   input  logic [WIDTH-1:0] i_par_in,
   output logic [WIDTH-1:0] o_q_next
);

   // Select hold / shift left / shift right / load; rotation recirculates the
   // bit falling off the far end instead of taking the serial fill bit.
   always_comb begin
      o_q_next = i_q;
      case (i_op)
         MODE_SHL:  o_q_next = {i_q[WIDTH-2:0], (i_rot ? i_q[WIDTH-1] : i_ser_r)};
         MODE_SHR:  o_q_next = {(i_rot ? i_q[0] : i_ser_l), i_q[WIDTH-1:1]};
         MODE_LOAD: o_q_next = i_par_in;
         default:   o_q_next = i_q;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with a multi-shift sequencer.
// Handshake: a multi-shift is requested by holding start high with mode SHL
// or SHR while busy is low; it is taken at that clock edge. busy stays high
// until the sequence finishes and done pulses for the last busy cycle. While
// busy is high every control input (mode, start, par_in) is ignored; the
// serial fill inputs are still sampled live on each sequencer step.
module univ_shift_reg
   import usk_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       mode,
   input  logic             rot,
   input  logic             ser_l,
   input  logic             ser_r,
   input  logic [WIDTH-1:0] par_in,
   input  logic             start,
   input  logic [CNT_W-1:0] amount,
   output logic [WIDTH-1:0] q,
   output logic             ser_out_l,
   output logic             ser_out_r,
   output logic             busy,
   output logic             done,
   output logic [1:0]       dbg_state
);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_dir;
   logic             r_rot;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_next;
   logic [1:0]       w_op;
   logic             w_rot;
   logic             w_accept;

   // A multi-shift is only taken from IDLE and only for a shifting mode;
   // start with HOLD or LOAD falls through to the direct op.
   assign w_accept = (r_state == ST_IDLE) && start &&
                     ((mode == MODE_SHL) || (mode == MODE_SHR));

   // Route either the live direct-op controls or the latched sequencer
   // controls into the shared mux; the acceptance edge and DONE hold q.
   always_comb begin
      w_op  = MODE_HOLD;
      w_rot = rot;
      case (r_state)
         ST_IDLE: begin
            if (!w_accept) begin
               w_op  = mode;
               w_rot = rot;
            end
         end
         ST_RUN: begin
            w_op  = r_dir;
            w_rot = r_rot;
         end
         default: begin
            w_op  = MODE_HOLD;
            w_rot = rot;
         end
      endcase
   end

   usr_next_val #(
      .WIDTH (WIDTH)
   ) u_next_val (
      .i_q      (r_q),
      .i_op     (w_op),
      .i_rot    (w_rot),
      .i_ser_l  (ser_l),
      .i_ser_r  (ser_r),
      .i_par_in (par_in),
      .o_q_next (w_q_next)
   );

   // Sequencer next state: zero-length requests go straight to DONE; RUN
   // leaves once the final step (count of one) is being applied.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_next = (amount == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (r_cnt == CNT_W'(1)) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // State register; reset aborts any sequence in flight without a done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Step counter and latched direction/rotate captured on acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_dir <= MODE_HOLD;
         r_rot <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= amount;
         r_dir <= mode;
         r_rot <= rot;
      end else if (r_state == ST_RUN) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Data register; the mux already folds in hold for idle-accept and DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else begin
         r_q <= w_q_next;
      end
   end

   assign q         = r_q;
   assign ser_out_l = r_q[WIDTH-1];
   assign ser_out_r = r_q[0];
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_DONE);
   assign dbg_state = r_state;

endmodule
